led_seq_ctrl: RTL and testbench



---
 rtl/led_seq_ctrl_pkg.sv | 27 ++
 rtl/led_seq_ctrl_if.sv | 17 +
 rtl/led_seq_ctrl_pattern_next.sv | 57 +++++
 rtl/led_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_led_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl_pkg
// Description : Shared encodings for the LED sequence controller: FSM states,
//               pattern mode codes and counter switch-word bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package led_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_PP  = 2'b10;
    localparam logic [1:0] MODE_CNT = 2'b11;

    localparam int SW_EN       = 0;
    localparam int SW_RATE_LSB = 1;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/led_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl_if
// Description : Link between the sequence controller (master) and the rate-tick
//               counter (slave): switch word out, tick valid back.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_seq_ctrl_if #(
    parameter int NB_SW = 3
);
    logic [NB_SW-1:0] sw;
    logic             valid;

    modport master (output sw, input valid);
    modport slave  (input sw, output valid);
endinterface
`default_nettype wire

// File: rtl/led_seq_ctrl_pattern_next.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_next
// Description : Combinational next-step function of the LED pattern engine;
//               o_wrap flags the step that returns the pattern to its seed.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_next
    import led_seq_ctrl_pkg::*;
#(
    parameter int NB_LED = 4
) (
    input  wire logic [1:0]        i_mode,
    input  wire logic [NB_LED-1:0] i_led,
    input  wire logic              i_dir,
    output logic      [NB_LED-1:0] o_next_led,
    output logic                   o_next_dir,
    output logic                   o_wrap
);

    localparam logic [NB_LED-1:0] C_SEED = {{(NB_LED-1){1'b0}}, 1'b1};

    always_comb begin
        o_next_led = i_led;
        o_next_dir = i_dir;
        o_wrap     = 1'b0;
        case (i_mode)
            MODE_ROL: begin
                o_next_led = {i_led[NB_LED-2:0], i_led[NB_LED-1]};
                o_wrap     = (o_next_led == C_SEED);
            end
            MODE_ROR: begin
                o_next_led = {i_led[0], i_led[NB_LED-1:1]};
                o_wrap     = (o_next_led == C_SEED);
            end
            MODE_PP: begin
                // Direction flips on arrival at an end so that end is never shown twice.
                if (i_dir == DIR_LEFT) begin
                    o_next_led = i_led << 1;
                    if (o_next_led[NB_LED-1]) o_next_dir = DIR_RIGHT;
                end else begin
                    o_next_led = i_led >> 1;
                    if (o_next_led[0]) begin
                        o_next_dir = DIR_LEFT;
                        o_wrap     = 1'b1;
                    end
                end
            end
            default: begin
                o_next_led = i_led + 1'b1;
                o_wrap     = (o_next_led == '0);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl
// Description : Sequences the rate-tick counter and steps an LED pattern on
//               each rising tick. Optional macro LED_SEQ_CYCLE_CNT_EN adds the
//               o_cycles completed-pattern counter.
// Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl
    import led_seq_ctrl_pkg::*;
#(
    parameter int NB_SW  = 3,
    parameter int NB_LED = 4,
    parameter int NB_CYC = 16
) (
    input  wire logic              clock,
    input  wire logic              i_reset,
    input  wire logic              i_start,
    input  wire logic              i_stop,
    input  wire logic              i_pause,
    input  wire logic [1:0]        i_mode,
    input  wire logic [1:0]        i_rate,
    led_seq_ctrl_if.master         cnt_if,
    output logic      [NB_LED-1:0] o_led,
    output logic                   o_busy
`ifdef LED_SEQ_CYCLE_CNT_EN
    ,
    output logic      [NB_CYC-1:0] o_cycles
`endif
);

    localparam logic [NB_LED-1:0] C_SEED = {{(NB_LED-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        r_mode_q;
    logic [1:0]        r_rate_q;
    logic              r_valid_d;
    logic              r_dir;
    logic [NB_LED-1:0] r_led;

    logic              w_tick;
    logic [NB_LED-1:0] w_next_led;
    logic              w_next_dir;
    logic              w_wrap;
    logic              w_step;
    logic [NB_SW-1:0]  w_sw;

    // Edge detect rejects the counter's level-held valid while it is disabled.
    assign w_tick = cnt_if.valid & ~r_valid_d;
    assign w_step = (r_state == ST_RUN) && w_tick && !i_stop && !i_pause;

    led_pattern_next #(
        .NB_LED     (NB_LED)
    ) u_pattern_next (
        .i_mode     (r_mode_q),
        .i_led      (r_led),
        .i_dir      (r_dir),
        .o_next_led (w_next_led),
        .o_next_dir (w_next_dir),
        .o_wrap     (w_wrap)
    );

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_mode_q  <= MODE_ROL;
            r_rate_q  <= 2'b00;
            r_valid_d <= 1'b0;
            r_dir     <= DIR_LEFT;
            r_led     <= '0;
        end else begin
            r_valid_d <= cnt_if.valid;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_stop) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_state  <= ST_RUN;
                    r_mode_q <= i_mode;
                    r_rate_q <= i_rate;
                    r_dir    <= DIR_LEFT;
                    r_led    <= (i_mode == MODE_CNT) ? '0 : C_SEED;
                end
                ST_RUN: begin
                    if (i_stop) begin
                        r_state <= ST_IDLE;
                        r_led   <= '0;
                    end else if (i_pause) begin
                        r_state <= ST_PAUSE;
                    end else if (w_tick) begin
                        // Rate is only resampled at a tick so the counter never wraps early.
                        r_led    <= w_next_led;
                        r_dir    <= w_next_dir;
                        r_rate_q <= i_rate;
                    end
                end
                default: begin
                    if (i_stop) begin
                        r_state <= ST_IDLE;
                        r_led   <= '0;
                    end else if (!i_pause) begin
                        r_state <= ST_RUN;
                    end
                end
            endcase
        end
    end

`ifdef LED_SEQ_CYCLE_CNT_EN
    logic [NB_CYC-1:0] r_cycles;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_cycles <= '0;
        end else if (r_state == ST_LOAD) begin
            r_cycles <= '0;
        end else if (w_step && w_wrap && (r_cycles != {NB_CYC{1'b1}})) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

    assign o_cycles = r_cycles;
`else
    logic w_unused_wrap;
    assign w_unused_wrap = w_wrap & w_step;
`endif

    always_comb begin
        w_sw                     = '0;
        w_sw[SW_EN]              = (r_state == ST_RUN);
        w_sw[SW_RATE_LSB +: 2]   = r_rate_q;
    end

    assign cnt_if.sw = w_sw;
    assign o_led     = r_led;
    assign o_busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Directed self-checking bench for led_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    logic       clock;
    logic       i_reset;
    logic       i_start;
    logic       i_stop;
    logic       i_pause;
    logic [1:0] i_mode;
    logic [1:0] i_rate;
    logic [3:0] o_led;
    logic       o_busy;
`ifdef LED_SEQ_CYCLE_CNT_EN
    logic [15:0] o_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    led_seq_ctrl_if #(.NB_SW(3)) u_if ();

    led_seq_ctrl #(
        .NB_SW   (3),
        .NB_LED  (4),
        .NB_CYC  (16)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_stop  (i_stop),
        .i_pause (i_pause),
        .i_mode  (i_mode),
        .i_rate  (i_rate),
        .cnt_if  (u_if.master),
        .o_led   (o_led),
        .o_busy  (o_busy)
`ifdef LED_SEQ_CYCLE_CNT_EN
        ,
        .o_cycles(o_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [1:0] mode, input logic [1:0] rate);
        i_mode  = mode;
        i_rate  = rate;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
    endtask

    // Valid rises for one cycle; o_led is sampled right after the rising edge.
    task automatic tick_rise();
        u_if.valid = 1'b1;
        step();
    endtask

    task automatic tick_fall(input int gap);
        u_if.valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic do_stop();
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        #2;
        n_checks++;
        if (o_led !== 4'b0000) begin n_fail++; $display("FAIL reset_led: got %b want 0000", o_led); end
        n_checks++;
        if (u_if.sw !== 3'b000) begin n_fail++; $display("FAIL reset_sw: got %b want 000", u_if.sw); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
`ifdef LED_SEQ_CYCLE_CNT_EN
        n_checks++;
        if (o_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d want 0", o_cycles); end
`endif
        step();
        i_reset = 1'b0;
        step();
    endtask

    task automatic test_rotate_left();
        logic [3:0] exp_led [4];
        exp_led = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        i_mode  = 2'b00;
        i_rate  = 2'b01;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        n_checks++;
        if (u_if.sw !== 3'b000 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL rol_load: sw=%b busy=%b want sw=000 busy=1", u_if.sw, o_busy);
        end
        step();
        n_checks++;
        if (u_if.sw !== 3'b011) begin n_fail++; $display("FAIL rol_run_sw: got %b want 011", u_if.sw); end
        n_checks++;
        if (o_led !== 4'b0001) begin n_fail++; $display("FAIL rol_seed: got %b want 0001", o_led); end
        for (int i = 0; i < 4; i++) begin
            tick_rise();
            n_checks++;
            if (o_led !== exp_led[i]) begin
                n_fail++; $display("FAIL rol_tick%0d: got %b want %b", i, o_led, exp_led[i]);
            end
            tick_fall(9);
        end
`ifdef LED_SEQ_CYCLE_CNT_EN
        n_checks++;
        if (o_cycles !== 16'd1) begin n_fail++; $display("FAIL rol_cycles: got %0d want 1", o_cycles); end
`endif
        do_stop();
        n_checks++;
        if (o_busy !== 1'b0 || o_led !== 4'b0000 || u_if.sw[0] !== 1'b0) begin
            n_fail++; $display("FAIL rol_stop: busy=%b led=%b en=%b want 0/0000/0", o_busy, o_led, u_if.sw[0]);
        end
    endtask

    task automatic test_rotate_right();
        logic [3:0] exp_led [4];
        exp_led = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        do_start(2'b01, 2'b00);
        for (int i = 0; i < 4; i++) begin
            tick_rise();
            n_checks++;
            if (o_led !== exp_led[i]) begin
                n_fail++; $display("FAIL ror_tick%0d: got %b want %b", i, o_led, exp_led[i]);
            end
            tick_fall(2);
        end
        do_stop();
    endtask

    task automatic test_ping_pong();
        logic [3:0] exp_led [8];
        exp_led = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        do_start(2'b10, 2'b01);
        n_checks++;
        if (o_led !== 4'b0001) begin n_fail++; $display("FAIL pp_seed: got %b want 0001", o_led); end
        for (int i = 0; i < 8; i++) begin
            tick_rise();
            n_checks++;
            if (o_led !== exp_led[i]) begin
                n_fail++; $display("FAIL pp_tick%0d: got %b want %b", i, o_led, exp_led[i]);
            end
            tick_fall(3);
        end
`ifdef LED_SEQ_CYCLE_CNT_EN
        n_checks++;
        if (o_cycles !== 16'd1) begin n_fail++; $display("FAIL pp_cycles: got %0d want 1", o_cycles); end
`endif
        do_stop();
    endtask

    task automatic test_count();
        logic [3:0] exp_v;
        do_start(2'b11, 2'b10);
        n_checks++;
        if (o_led !== 4'b0000) begin n_fail++; $display("FAIL cnt_seed: got %b want 0000", o_led); end
        exp_v = 4'd0;
        for (int i = 0; i < 17; i++) begin
            exp_v = exp_v + 4'd1;
            tick_rise();
            n_checks++;
            if (o_led !== exp_v) begin
                n_fail++; $display("FAIL cnt_tick%0d: got %b want %b", i, o_led, exp_v);
            end
            tick_fall(2);
        end
        do_stop();
    endtask

    task automatic test_rate_hold();
        do_start(2'b00, 2'b11);
        n_checks++;
        if (u_if.sw !== 3'b111) begin n_fail++; $display("FAIL rate_init: got %b want 111", u_if.sw); end
        i_rate = 2'b00;
        repeat (4) step();
        n_checks++;
        if (u_if.sw[2:1] !== 2'b11) begin n_fail++; $display("FAIL rate_hold: got %b want 11", u_if.sw[2:1]); end
        tick_rise();
        n_checks++;
        if (u_if.sw !== 3'b001) begin n_fail++; $display("FAIL rate_update: got %b want 001", u_if.sw); end
        tick_fall(2);
    endtask

    // Continues from RUN with o_led=0010 left by test_rate_hold.
    task automatic test_pause();
        i_pause    = 1'b1;
        u_if.valid = 1'b1;
        step();
        n_checks++;
        if (o_led !== 4'b0010) begin n_fail++; $display("FAIL pause_tick_edge: got %b want 0010", o_led); end
        repeat (20) step();
        n_checks++;
        if (u_if.sw[0] !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL pause_sw: en=%b busy=%b want 0/1", u_if.sw[0], o_busy);
        end
        i_pause = 1'b0;
        step();
        n_checks++;
        if (u_if.sw[0] !== 1'b1) begin n_fail++; $display("FAIL pause_resume: en=%b want 1", u_if.sw[0]); end
        repeat (3) step();
        n_checks++;
        if (o_led !== 4'b0010) begin n_fail++; $display("FAIL pause_spurious: got %b want 0010", o_led); end
        tick_fall(2);
    endtask

    task automatic test_stop_with_tick();
        i_stop     = 1'b1;
        u_if.valid = 1'b1;
        step();
        i_stop = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_led !== 4'b0000) begin
            n_fail++; $display("FAIL stop_tick: busy=%b led=%b want 0/0000", o_busy, o_led);
        end
        tick_fall(2);
    endtask

    task automatic test_async_reset();
        do_start(2'b00, 2'b10);
        tick_rise();
        tick_fall(1);
        #3;
        i_reset = 1'b1;
        #1;
        n_checks++;
        if (o_led !== 4'b0000 || u_if.sw !== 3'b000 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: led=%b sw=%b busy=%b want 0000/000/0", o_led, u_if.sw, o_busy);
        end
        step();
        i_reset = 1'b0;
        step();
    endtask

    task automatic test_start_stop();
        i_start = 1'b1;
        i_stop  = 1'b1;
        step();
        i_start = 1'b0;
        i_stop  = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_busy: got %b want 0", o_busy); end
        step();
        n_checks++;
        if (o_busy !== 1'b0 || u_if.sw[0] !== 1'b0) begin
            n_fail++; $display("FAIL start_stop_idle: busy=%b en=%b want 0/0", o_busy, u_if.sw[0]);
        end
    endtask

    initial begin
        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_pause    = 1'b0;
        i_mode     = 2'b00;
        i_rate     = 2'b00;
        u_if.valid = 1'b0;
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_ping_pong();
        test_count();
        test_rate_hold();
        test_pause();
        test_stop_with_tick();
        test_async_reset();
        test_start_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
